// File: rtl/click_to_sync_bridge.sv
// Click drive/free handshake to clocked FWFT valid/ready bridge with toggle synchronizer and small FIFO.
// Optional token/stall statistics counters are enabled by defining CLICK_BRIDGE_STATS_EN.
module click_to_sync_bridge #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FREE_PULSE  = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_drive,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_free,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_ovf
`ifdef CLICK_BRIDGE_STATS_EN
 ,output logic [15:0]                  o_tok_cnt,
  output logic [15:0]                  o_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int FC_W  = (FREE_PULSE > 1) ? $clog2(FREE_PULSE) : 1;

  typedef enum logic [1:0] {IDLE, FREE, WAIT_SPACE} state_t;

  logic [DATA_WIDTH-1:0] cap_reg;
  logic                  tog_reg;
  logic [SYNC_STAGES:0]  sync_reg;
  logic                  tok_evt;
  logic                  full, push, pop;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_t                state_reg, state_next;
  logic [FC_W-1:0]       fcnt_reg, fcnt_next;
  logic                  free_reg;
  logic                  ovf_reg;

  // The merge holds i_data until o_free, so cap_reg is stable while the toggle crosses.
  always_ff @(posedge i_drive or negedge rstn) begin
    if (!rstn) begin
      cap_reg <= '0;
      tog_reg <= 1'b0;
    end else begin
      cap_reg <= i_data;
      tog_reg <= ~tog_reg;
    end
  end

  // SYNC_STAGES synchronizer flops plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_reg <= '0;
    else       sync_reg <= {sync_reg[SYNC_STAGES-1:0], tog_reg};
  end

  assign tok_evt    = sync_reg[SYNC_STAGES] ^ sync_reg[SYNC_STAGES-1];
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign o_valid    = (count_reg != '0);
  assign push       = tok_evt & ~full;
  assign pop        = o_valid & i_ready;
  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= cap_reg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign o_data  = o_valid ? mem[rd_ptr_reg] : '0;
  assign o_count = count_reg;

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    case (state_reg)
      IDLE: ;
      WAIT_SPACE: begin
        if (pop) begin
          state_next = FREE;
          fcnt_next  = '0;
        end
      end
      FREE: begin
        if (fcnt_reg == FC_W'(FREE_PULSE-1)) state_next = IDLE;
        else                                 fcnt_next  = fcnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Any token, legal or not, restarts the free decision from the new occupancy.
    if (tok_evt) begin
      fcnt_next  = '0;
      state_next = (count_next < CNT_W'(DEPTH)) ? FREE : WAIT_SPACE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      fcnt_reg  <= '0;
      free_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      free_reg  <= (state_next == FREE);
      ovf_reg   <= ovf_reg | (tok_evt & (full | (state_reg != IDLE)));
    end
  end

  assign o_free = free_reg;
  assign o_ovf  = ovf_reg;

`ifdef CLICK_BRIDGE_STATS_EN
  logic [15:0] tok_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tok_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (push && tok_cnt_reg != 16'hFFFF) tok_cnt_reg <= tok_cnt_reg + 1'b1;
      if (state_reg == WAIT_SPACE && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign o_tok_cnt   = tok_cnt_reg;
  assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_click_to_sync_bridge.sv
// Scoreboard bench for click_to_sync_bridge: stimulus pushes expected tokens, a monitor pops on each accepted head.
module tb_click_to_sync_bridge;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          i_drive = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_free, o_valid, o_ovf;
  logic [DW-1:0] o_data;
  logic [2:0]    o_count;
`ifdef CLICK_BRIDGE_STATS_EN
  logic [15:0]   o_tok_cnt, o_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  logic ready_cmd = 1'b0;
  logic rnd_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  click_to_sync_bridge #(.DATA_WIDTH(DW), .DEPTH(4), .SYNC_STAGES(SS), .FREE_PULSE(2)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_drive (i_drive),
    .i_data  (i_data),
    .o_free  (o_free),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_count (o_count),
    .o_ovf   (o_ovf)
`ifdef CLICK_BRIDGE_STATS_EN
   ,.o_tok_cnt   (o_tok_cnt),
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // i_ready changes only 1ns after a rising edge, so the monitor sees a settled value.
  always @(posedge clk) begin
    #1;
    i_ready = rnd_en ? ($urandom_range(9, 0) >= 3) : ready_cmd;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected act=0x%0h exp=none", o_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        $display("rx data=0x%02h exp=0x%02h", o_data, e);
        check("rx_data", {24'd0, o_data}, {24'd0, e});
      end
      rx_cnt++;
    end
  end

  task automatic send_token(input logic [DW-1:0] d, input bit expect_it);
    i_data = d;
    if (expect_it) exp_q.push_back(d);
    $display("tx data=0x%02h expected=%0d", d, expect_it);
    #1 i_drive = 1'b1;
    #3 i_drive = 1'b0;
  endtask

  task automatic wait_free(input string nm);
    int n = 0;
    while (!o_free && n < 400) begin @(negedge clk); n++; end
    check({nm, "_seen"}, {31'd0, o_free}, 32'd1);
    while (o_free && n < 800) begin @(negedge clk); n++; end
  endtask

  task automatic wait_count(input logic [2:0] v, input string nm);
    int n = 0;
    while (o_count !== v && n < 100) begin @(negedge clk); n++; end
    check(nm, {29'd0, o_count}, {29'd0, v});
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || o_count != 0) && n < 2000) begin @(negedge clk); n++; end
    check(nm, exp_q.size(), 32'd0);
  endtask

  initial begin
    int first, free_hi, max_cnt, rx0, nw;
    bit ovf_seen;

    #2 rstn = 1'b0;
    #1;
    check("rst_free", {31'd0, o_free}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data", {24'd0, o_data}, 32'd0);
    check("rst_count", {29'd0, o_count}, 32'd0);
    check("rst_ovf", {31'd0, o_ovf}, 32'd0);
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;

    // Single token with a free-running consumer.
    ready_cmd = 1'b1;
    repeat (3) @(negedge clk);
    send_token(8'h5A, 1'b1);
    first = 0; free_hi = 0; max_cnt = 0; ovf_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (o_valid && first == 0) first = i;
      if (o_free) free_hi++;
      if (o_count > max_cnt) max_cnt = o_count;
      if (o_ovf) ovf_seen = 1'b1;
    end
    check("tok1_latency_ok", {31'd0, (first >= 1 && first <= SS + 2)}, 32'd1);
    check("tok1_free_cycles", free_hi, 32'd2);
    check("tok1_max_count", max_cnt, 32'd1);
    check("tok1_count_end", {29'd0, o_count}, 32'd0);
    check("tok1_ovf", {31'd0, ovf_seen}, 32'd0);

    // Backpressure fill up to WAIT_SPACE.
    ready_cmd = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      send_token(DW'(k), 1'b1);
      if (k < 4) wait_free("bp_free");
    end
    wait_count(3'd4, "bp_full");
    free_hi = 0;
    repeat (10) begin @(negedge clk); if (o_free) free_hi++; end
    check("bp_no_free", free_hi, 32'd0);
    check("bp_count_hold", {29'd0, o_count}, 32'd4);
`ifdef CLICK_BRIDGE_STATS_EN
    check("stats_tok_cnt", {16'd0, o_tok_cnt}, 32'd4);
    check("stats_stall_cnt", {16'd0, o_stall_cnt}, 32'd10);
`endif
    ready_cmd = 1'b1;
    @(posedge clk);
    #2 ready_cmd = 1'b0;
    wait_free("bp_pop_free");
    check("bp_count_after_pop", {29'd0, o_count}, 32'd3);

    // Refill, then drive into a full FIFO.
    send_token(8'h05, 1'b1);
    wait_count(3'd4, "ovf_refill");
    send_token(8'h66, 1'b0);
    repeat (8) @(negedge clk);
    check("ovf_flag", {31'd0, o_ovf}, 32'd1);
    check("ovf_count_hold", {29'd0, o_count}, 32'd4);
    ready_cmd = 1'b1;
    wait_empty("ovf_drain");
    repeat (10) @(negedge clk);
    check("ovf_sticky", {31'd0, o_ovf}, 32'd1);

    // Reset during the first cycle of o_free.
    ready_cmd = 1'b0;
    repeat (2) @(negedge clk);
    send_token(8'h3C, 1'b1);
    nw = 0;
    while (!o_free && nw < 50) begin @(negedge clk); nw++; end
    check("mid_free_seen", {31'd0, o_free}, 32'd1);
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_free", {31'd0, o_free}, 32'd0);
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_count", {29'd0, o_count}, 32'd0);
    check("mid_rst_ovf", {31'd0, o_ovf}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    ready_cmd = 1'b1;
    repeat (3) @(negedge clk);
    rx0 = rx_cnt;
    send_token(8'h77, 1'b1);
    wait_free("post_rst_free");
    wait_empty("post_rst_drain");
    check("post_rst_rx", rx_cnt - rx0, 32'd1);

    // Ordering under random backpressure.
    rx0 = rx_cnt;
    rnd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_token(8'h10 + DW'(i), 1'b1);
      wait_free("ord_free");
    end
    wait_empty("ord_drain");
    rnd_en = 1'b0;
    repeat (4) @(negedge clk);
    check("ord_rx_total", rx_cnt - rx0, 32'd16);
    check("ord_ovf", {31'd0, o_ovf}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
